// File: rtl/input_debouncer_if.sv
// Bus bundle for the input debouncer.
//   enable     : freeze counters/levels and silence strobes when low
//   raw_in     : asynchronous pad inputs
//   clean_out  : debounced level per bit
//   rise_out   : one-cycle 0->1 strobe per bit
//   fall_out   : one-cycle 1->0 strobe per bit
//   any_change : OR of all strobes, same cycle as the strobes
interface input_debouncer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;
  logic             any_change;

  modport master (
    output enable, raw_in,
    input  clean_out, rise_out, fall_out, any_change
  );

  modport slave (
    input  enable, raw_in,
    output clean_out, rise_out, fall_out, any_change
  );
endinterface

// File: rtl/input_debouncer.sv
// Input debouncer: two-flop synchroniser per bit, then a per-bit stability counter.
// A bit's clean level flips only after the synchronised value has differed from it for
// STABLE_CYCLES consecutive enabled cycles; rise/fall strobes mark the flip cycle.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : input_debouncer_if slave (enable, raw_in in; clean/rise/fall/any_change out)
module input_debouncer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 5000,
  localparam int unsigned CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input_debouncer_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_any;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_clean_d;
  logic [WIDTH-1:0] w_rise_d;
  logic [WIDTH-1:0] w_fall_d;
  logic [CNT_W-1:0] w_cnt_d [WIDTH];

  always_comb begin
    w_clean_d = r_clean;
    w_rise_d  = '0;
    w_fall_d  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_cnt_d[i] = r_cnt[i];
    end
    if (bus.enable) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_clean[i]) begin
          // Any return to the clean level discards partial progress.
          w_cnt_d[i] = '0;
        end else if (r_cnt[i] == CntMax) begin
          w_clean_d[i] = r_sync2[i];
          w_rise_d[i]  = r_sync2[i];
          w_fall_d[i]  = ~r_sync2[i];
          w_cnt_d[i]   = '0;
        end else begin
          w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_any   <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      // Synchroniser runs regardless of enable so it never holds stale pad data.
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
      r_clean <= w_clean_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
      r_any   <= |(w_rise_d | w_fall_d);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign bus.clean_out  = r_clean;
  assign bus.rise_out   = r_rise;
  assign bus.fall_out   = r_fall;
  assign bus.any_change = r_any;

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  localparam int SC = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  input_debouncer_if #(.WIDTH(8)) bus ();
  input_debouncer_if #(.WIDTH(8)) bus1 ();

  assign bus1.raw_in = bus.raw_in;
  assign bus1.enable = bus.enable;

  input_debouncer #(.WIDTH(8), .STABLE_CYCLES(SC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Boundary instance: one-cycle stability requirement.
  input_debouncer #(.WIDTH(8), .STABLE_CYCLES(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each bit tracks how many consecutive enabled cycles its
  // synchronised value has disagreed with the clean level.
  logic [7:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  logic       m_any;
  int         m_run [8];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [7:0] nr, nf;
    nr = '0;
    nf = '0;
    if (bus.enable) begin
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] == m_clean[i]) begin
          m_run[i] = 0;
        end else if (m_run[i] + 1 == SC) begin
          m_clean[i] = m_s2[i];
          if (m_s2[i]) nr[i] = 1'b1;
          else nf[i] = 1'b1;
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
        end
      end
    end
    m_rise = nr;
    m_fall = nf;
    m_any  = |(nr | nf);
    m_s2   = m_s1;
    m_s1   = bus.raw_in;
  endtask

  // Advance one edge; leaves time at posedge+1 for sampling and driving.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic settle(input logic [7:0] v);
    bus.raw_in = v;
    repeat (SC + 6) tick();
  endtask

  task automatic test_reset();
    bus.raw_in = 8'hFF;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change} !== 25'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0",
               {bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change});
    end
    rst_n = 1'b1;
    repeat (SC + 4) tick();
    checks++;
    if (bus.clean_out !== 8'hFF) begin
      failures++;
      $display("FAIL reset_prefill got=%h exp=ff", bus.clean_out);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change} !== 25'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0",
               {bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change});
    end
    bus.raw_in = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if ({bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change} !== 25'h0) begin
        failures++;
        $display("FAIL reset_quiet cycle=%0d got=%h exp=0", c,
                 {bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change});
      end
    end
  endtask

  task automatic test_clean_step();
    bus.raw_in = 8'h81;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (bus.clean_out !== ((e >= SC + 2) ? 8'h81 : 8'h00) ||
          bus.rise_out !== ((e == SC + 2) ? 8'h81 : 8'h00) ||
          bus.fall_out !== 8'h00 || bus.any_change !== (e == SC + 2)) begin
        failures++;
        $display("FAIL clean_step edge=%0d got=%h/%h/%h/%b", e, bus.clean_out,
                 bus.rise_out, bus.fall_out, bus.any_change);
      end
      checks++;
      if (bus1.clean_out !== ((e >= 3) ? 8'h81 : 8'h00) ||
          bus1.rise_out !== ((e == 3) ? 8'h81 : 8'h00)) begin
        failures++;
        $display("FAIL stable1_step edge=%0d got=%h/%h", e, bus1.clean_out, bus1.rise_out);
      end
    end
  endtask

  task automatic test_bounce();
    int rises;
    int rise_edge;
    logic [7:0] pat;
    settle(8'h00);
    rises = 0;
    rise_edge = -1;
    pat = 8'b0000_0101;
    for (int p = 0; p < 4; p++) begin
      bus.raw_in = {7'b0, pat[p]};
      repeat (2) begin
        tick();
        if (bus.rise_out[0]) rises++;
      end
    end
    bus.raw_in = 8'h01;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.rise_out[0]) begin
        rises++;
        rise_edge = e;
      end
      checks++;
      if ({bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change} !==
          {m_clean, m_rise, m_fall, m_any}) begin
        failures++;
        $display("FAIL bounce_model edge=%0d got=%h exp=%h", e,
                 {bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change},
                 {m_clean, m_rise, m_fall, m_any});
      end
    end
    checks++;
    if (rises !== 1 || rise_edge !== SC + 2) begin
      failures++;
      $display("FAIL bounce_timing got=rises %0d at edge %0d exp=1 at edge %0d",
               rises, rise_edge, SC + 2);
    end
  endtask

  task automatic test_enable_freeze();
    int strobes;
    settle(8'h00);
    strobes = 0;
    bus.raw_in = 8'h08;
    repeat (4) tick();
    bus.enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.clean_out !== 8'h00 || bus.rise_out !== 8'h00 || bus.any_change !== 1'b0) begin
        failures++;
        $display("FAIL freeze_hold cycle=%0d got=%h/%h/%b", c, bus.clean_out,
                 bus.rise_out, bus.any_change);
      end
    end
    bus.enable = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (bus.rise_out[3]) strobes++;
      checks++;
      if (bus.clean_out[3] !== (e >= 2) || bus.rise_out !== ((e == 2) ? 8'h08 : 8'h00)) begin
        failures++;
        $display("FAIL freeze_resume edge=%0d got=%h/%h", e, bus.clean_out, bus.rise_out);
      end
    end
    checks++;
    if (strobes !== 1) begin
      failures++;
      $display("FAIL freeze_strobes got=%0d exp=1", strobes);
    end
  endtask

  task automatic test_fall_mixed();
    settle(8'hF0);
    checks++;
    if (bus.clean_out !== 8'hF0) begin
      failures++;
      $display("FAIL mixed_setup got=%h exp=f0", bus.clean_out);
    end
    bus.raw_in = 8'h0F;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (bus.clean_out !== ((e >= SC + 2) ? 8'h0F : 8'hF0) ||
          bus.rise_out !== ((e == SC + 2) ? 8'h0F : 8'h00) ||
          bus.fall_out !== ((e == SC + 2) ? 8'hF0 : 8'h00) ||
          bus.any_change !== (e == SC + 2)) begin
        failures++;
        $display("FAIL mixed_edges edge=%0d got=%h/%h/%h/%b", e, bus.clean_out,
                 bus.rise_out, bus.fall_out, bus.any_change);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    settle(8'h00);
    bus.raw_in = 8'h80;
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.clean_out !== 8'h00) begin
      failures++;
      $display("FAIL midreset_clear got=%h exp=00", bus.clean_out);
    end
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (bus.clean_out !== ((e >= SC + 2) ? 8'h80 : 8'h00) ||
          bus.rise_out !== ((e == SC + 2) ? 8'h80 : 8'h00)) begin
        failures++;
        $display("FAIL midreset_latency edge=%0d got=%h/%h", e, bus.clean_out, bus.rise_out);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    int changes;
    r = bus.raw_in;
    changes = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 8; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
      bus.raw_in = r;
      bus.enable = ($urandom_range(9) != 0);
      tick();
      if (m_any) changes++;
      checks++;
      if ({bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change} !==
          {m_clean, m_rise, m_fall, m_any}) begin
        failures++;
        $display("FAIL random_model cycle=%0d got=%h exp=%h", c,
                 {bus.clean_out, bus.rise_out, bus.fall_out, bus.any_change},
                 {m_clean, m_rise, m_fall, m_any});
      end
      checks++;
      if ((bus.rise_out & bus.fall_out) !== 8'h00) begin
        failures++;
        $display("FAIL random_exclusive cycle=%0d got=%h exp=00", c,
                 bus.rise_out & bus.fall_out);
      end
    end
    bus.enable = 1'b1;
    checks++;
    if (changes == 0) begin
      failures++;
      $display("FAIL random_activity got=0 changes exp=some");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.raw_in = 8'h00;
    model_reset();
    test_reset();
    test_clean_step();
    test_bounce();
    test_enable_freeze();
    test_fall_mixed();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the user input bus.
- Synchronises each bit of the raw pad inputs into the clock domain and debounces it with a per-bit stability counter.
- Emits the clean levels, plus one-cycle rise and fall strobes per bit.
- The clean bus feeds the nibble adder, and through it the breathing-LED enable, so switch bounce cannot toggle the LED enable or glitch the sum.

Parameters:
- WIDTH, 8: number of input bits debounced independently.
- STABLE_CYCLES, 5000: consecutive cycles a synchronised bit must differ from its clean value before the clean value flips. 5 ms at 1 MHz. Legal range is 1 or more.
- CNT_W, $clog2(STABLE_CYCLES+1): counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock (1 MHz nominal).
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when low, freezes all counters and clean levels and forces strobes to 0.
- raw_in  input  WIDTH  asynchronous pad inputs (ui_in).
- clean_out  output  WIDTH  debounced level per bit.
- rise_out  output  WIDTH  one-cycle pulse when clean_out[i] goes 0->1.
- fall_out  output  WIDTH  one-cycle pulse when clean_out[i] goes 1->0.
- any_change  output  1  OR of all rise_out and fall_out bits, registered in the same cycle as the strobes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both synchroniser stages, clean_out, all counters, rise_out, fall_out and any_change clear to 0 immediately.
  - Outputs are registered, so they remain 0 until a qualifying stable input is seen after release.
- Synchroniser:
  - Two flops per bit: s1 <= raw_in; s2 <= s1.
  - Always clocked, independent of enable.
- Per-bit counter, each rising edge with enable=1:
  - s2[i]==clean_out[i]: cnt[i] <= 0.
  - s2[i]!=clean_out[i] and cnt[i]==STABLE_CYCLES-1: clean_out[i] <= s2[i]; cnt[i] <= 0; the matching strobe asserts.
  - Otherwise: cnt[i] <= cnt[i]+1.
- Latency:
  - A raw change that first meets setup at edge 1 appears on clean_out after edge STABLE_CYCLES+2.
  - Example: STABLE_CYCLES=4 gives edge 6.
- Strobes:
  - rise_out[i] / fall_out[i] are high for exactly one cycle, the same cycle clean_out[i] shows its new value.
  - Strobes are 0 in every other cycle.
  - rise_out[i] and fall_out[i] are never simultaneously high.
- Glitch rejection:
  - Any return of s2[i] to clean_out[i] before the count completes clears cnt[i] to 0.
  - No change and no strobe result; a later attempt restarts the count from 0.
- Independence:
  - Bits never share counters.
  - Simultaneous flips on several bits each complete on their own schedule.
  - Multiple strobe bits may be high in one cycle.
- enable=0:
  - cnt and clean_out hold their values.
  - rise_out, fall_out and any_change are 0 on the next edge.
  - On re-enable, counting resumes from the held cnt.
- STABLE_CYCLES=1: clean_out follows s2 one edge after s2 differs (total 3 edges).
- Counter saturation: cnt never exceeds STABLE_CYCLES-1, and CNT_W never overflows.
- Reset mid-count: all state is discarded and counting restarts from 0 after release.
- Implementation: purely synchronous after the asynchronous clear; no latches and no combinational paths from raw_in to any output.

Test Plan:
- Reset: hold rst_n=0 with raw_in=8'hFF, assert rst_n=0 mid-cycle -> all outputs 0 immediately. After release with raw_in=0, outputs stay 0 for 100 cycles.
- Clean step: STABLE_CYCLES=4, enable=1, raw_in 8'h00->8'h81 before edge 1 -> clean_out=8'h81 after edge 6; rise_out=8'h81 and any_change=1 for that one cycle only; fall_out=0 throughout.
- Bounce: STABLE_CYCLES=4, raw_in[0] toggled 1,0,1,0 every 2 cycles, then held at 1 -> clean_out[0] rises exactly 6 edges after the final 0->1 transition; exactly one rise_out[0] pulse.
- Enable freeze: begin a 0->1 step on bit 3, drop enable after 2 counts for 10 cycles, then restore -> no change while disabled; clean_out[3] flips 2 counted edges after re-enable; one strobe.
- Fall and mixed edges: from clean_out=8'hF0, set raw_in=8'h0F -> after edge 6, clean_out=8'h0F, rise_out=8'h0F, fall_out=8'hF0 and any_change=1 in the same single cycle.
- Reset mid-count: start a step on bit 7, pulse rst_n low after 3 counts with raw_in still 8'h80 -> after release, clean_out[7]=1 only after a full 6-edge latency.
